// File: rtl/v4_input_conditioner.sv
// v4 front end: button sync/debounce with click pulse,
// plus a valid/ready word serializer feeding the 011 detector.
module v4_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int WORD_W          = 10,
  parameter int LEN_W           = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_raw,
  input  logic [WORD_W-1:0] word_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              click_out,
  output logic              btn_level,
  output logic              bit_out,
  output logic              bit_valid
);

  localparam int GW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_click;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_click <= 1'b0;
    end else begin
      r_s1    <= btn_raw;
      r_s2    <= r_s1;
      r_click <= 1'b0;
      if (r_s2 != r_level) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= r_s2;
          r_cnt   <= '0;
          r_click <= r_s2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign click_out = r_click;
  assign btn_level = r_level;

  state_t            r_state;
  logic [WORD_W-1:0] r_word;
  logic [LEN_W-1:0]  r_idx;
  logic [GW-1:0]     r_gap;
  logic              r_bit;
  logic              r_bval;

  state_t            w_nstate;
  logic [WORD_W-1:0] w_nword;
  logic [LEN_W-1:0]  w_nidx;
  logic [GW-1:0]     w_ngap;
  logic              w_nbit;
  logic              w_nbval;
  logic [LEN_W-1:0]  w_len;
  logic              w_hs;

  // Lengths beyond the word width clamp to the full word.
  assign w_len = (len_in > LEN_W'(WORD_W)) ?
                 LEN_W'(WORD_W) : len_in;

  assign word_ready = rst && (r_state == S_IDLE);
  assign w_hs       = word_valid && word_ready;

  always_comb begin
    w_nstate = r_state;
    w_nword  = r_word;
    w_nidx   = r_idx;
    w_ngap   = r_gap;
    w_nbit   = 1'b0;
    w_nbval  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs && (w_len != '0)) begin
          w_nword  = word_in;
          w_nidx   = w_len - 1'b1;
          w_nbit   = word_in[w_len - 1'b1];
          w_nbval  = 1'b1;
          w_nstate = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_idx == '0) begin
          if (GAP_CYCLES > 0) begin
            w_nstate = S_GAP;
            w_ngap   = GW'(GAP_CYCLES - 1);
          end else begin
            w_nstate = S_IDLE;
          end
        end else begin
          w_nidx  = r_idx - 1'b1;
          w_nbit  = r_word[r_idx - 1'b1];
          w_nbval = 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap == '0) begin
          w_nstate = S_IDLE;
        end else begin
          w_ngap = r_gap - 1'b1;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      r_bit   <= 1'b0;
      r_bval  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_word  <= w_nword;
      r_idx   <= w_nidx;
      r_gap   <= w_ngap;
      r_bit   <= w_nbit;
      r_bval  <= w_nbval;
    end
  end

  assign bit_out   = r_bit;
  assign bit_valid = r_bval;

endmodule

// File: tb/tb_v4_input_conditioner.sv
// Directed + random bench for v4_input_conditioner against a
// cycle-level behavioural model of debounce and serializer timing.
module tb_v4_input_conditioner;

  localparam int D   = 4;
  localparam int CW  = 3;
  localparam int W   = 10;
  localparam int LW  = 4;
  localparam int GAP = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn_raw = 1'b0;
  logic [W-1:0]  word_in = '0;
  logic [LW-1:0] len_in = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          click_out;
  logic          btn_level;
  logic          bit_out;
  logic          bit_valid;

  v4_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(CW),
    .WORD_W(W),
    .LEN_W(LW),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .word_in(word_in),
    .len_in(len_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .click_out(click_out),
    .btn_level(btn_level),
    .bit_out(bit_out),
    .bit_valid(bit_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  bit m_q[$];
  bit m_dl[$];
  int m_wait = 0;
  bit m_bit = 0;
  bit m_bval = 0;
  bit m_lvl = 0;
  bit m_click = 0;
  int m_streak = 0;

  int          o_clicks;
  int          o_click_at;
  int          o_lvl_at;
  int          o_nval;
  int          o_nrdy0;
  logic [15:0] o_cap;
  logic        prev_lvl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h at edge %0d",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit hs;
    bit s2;
    int l;
    if (!rst) begin
      m_q.delete();
      m_dl = {1'b0, 1'b0};
      m_wait = 0;
      m_bit = 0;
      m_bval = 0;
      m_lvl = 0;
      m_click = 0;
      m_streak = 0;
      return;
    end
    hs = word_valid && (m_wait == 0);
    l = (int'(len_in) > W) ? W : int'(len_in);
    if (m_wait > 0) m_wait--;
    m_bit = 0;
    m_bval = 0;
    if (m_q.size() > 0) begin
      m_bit = m_q.pop_front();
      m_bval = 1;
    end
    if (hs && l > 0) begin
      for (int i = l - 1; i >= 0; i--) m_q.push_back(word_in[i]);
      m_bit = m_q.pop_front();
      m_bval = 1;
      m_wait = l + GAP;
    end
    s2 = m_dl.pop_front();
    m_dl.push_back(btn_raw);
    m_click = 0;
    if (s2 != m_lvl) begin
      m_streak++;
      if (m_streak == D) begin
        m_lvl = s2;
        m_streak = 0;
        m_click = s2;
      end
    end else begin
      m_streak = 0;
    end
  endtask

  task automatic clr_obs();
    o_clicks = 0;
    o_click_at = -1;
    o_lvl_at = -1;
    o_nval = 0;
    o_nrdy0 = 0;
    o_cap = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("click", click_out, m_click);
    chk("level", btn_level, m_lvl);
    chk("bit_valid", bit_valid, m_bval);
    chk("bit_out", bit_out, m_bit);
    chk("ready", word_ready, rst && (m_wait == 0));
    if (click_out) begin
      o_clicks++;
      o_click_at = cyc;
    end
    if (btn_level !== prev_lvl) o_lvl_at = cyc;
    prev_lvl = btn_level;
    if (bit_valid) begin
      o_nval++;
      o_cap = {o_cap[14:0], bit_out};
    end
    if (!word_ready) o_nrdy0++;
  endtask

  int e;
  logic [W-1:0] w;

  initial begin
    clr_obs();
    rst = 1'b0;
    btn_raw = 1'b1;
    word_valid = 1'b1;
    len_in = 4'd10;
    word_in = W'($urandom);
    repeat (4) cycle();
    chk("rst_nobits", o_nval, 0);
    chk("rst_ready0", o_nrdy0, 4);
    chk("rst_noclick", o_clicks, 0);

    btn_raw = 1'b0;
    word_valid = 1'b0;
    rst = 1'b1;
    cycle();
    chk("rel_ready", word_ready, 1'b1);
    repeat (4) cycle();

    clr_obs();
    btn_raw = 1'b1;
    e = cyc + 1;
    repeat (20) cycle();
    chk("press_n", o_clicks, 1);
    chk("press_at", o_click_at, e + 1 + D);
    chk("press_lvl_at", o_lvl_at, e + 1 + D);

    clr_obs();
    btn_raw = 1'b0;
    e = cyc + 1;
    repeat (20) cycle();
    chk("rel_nclick", o_clicks, 0);
    chk("rel_lvl_at", o_lvl_at, e + 1 + D);
    chk("rel_lvl", btn_level, 1'b0);

    clr_obs();
    for (int i = 0; i < 8; i++) begin
      btn_raw = (i % 2 == 0);
      cycle();
    end
    chk("bounce_nclick", o_clicks, 0);
    btn_raw = 1'b1;
    e = cyc + 1;
    repeat (20) cycle();
    chk("bounce_n", o_clicks, 1);
    chk("bounce_at", o_click_at, e + 1 + D);
    btn_raw = 1'b0;
    repeat (15) cycle();

    clr_obs();
    word_in = 10'b0110011011;
    len_in = 4'd10;
    word_valid = 1'b1;
    cycle();
    word_valid = 1'b0;
    repeat (14) cycle();
    chk("t4_bits", o_cap, 16'h019B);
    chk("t4_nvalid", o_nval, 10);
    chk("t4_nready0", o_nrdy0, 11);

    clr_obs();
    len_in = 4'd0;
    word_valid = 1'b1;
    cycle();
    word_valid = 1'b0;
    repeat (3) cycle();
    chk("len0_nvalid", o_nval, 0);
    chk("len0_nready0", o_nrdy0, 0);

    clr_obs();
    w = W'($urandom);
    word_in = w;
    len_in = 4'd15;
    word_valid = 1'b1;
    cycle();
    word_valid = 1'b0;
    repeat (13) cycle();
    chk("len15_nvalid", o_nval, 10);
    chk("len15_bits", o_cap[9:0], w);
    chk("len15_nready0", o_nrdy0, 11);

    clr_obs();
    word_in = W'($urandom) | W'(1);
    len_in = 4'd1;
    word_valid = 1'b1;
    cycle();
    word_valid = 1'b0;
    repeat (3) cycle();
    chk("len1_nvalid", o_nval, 1);
    chk("len1_bit", o_cap, 16'h0001);
    chk("len1_nready0", o_nrdy0, 2);

    clr_obs();
    word_in = W'($urandom);
    len_in = 4'd10;
    word_valid = 1'b1;
    cycle();
    word_valid = 1'b0;
    repeat (3) cycle();
    chk("abort_pre_n", o_nval, 4);
    rst = 1'b0;
    word_valid = 1'b1;
    w = W'($urandom);
    word_in = w;
    cycle();
    chk("abort_bv", bit_valid, 1'b0);
    chk("abort_ready", word_ready, 1'b0);

    rst = 1'b1;
    clr_obs();
    repeat (11) cycle();
    chk("restart_bits", o_cap[9:0], w);
    chk("restart_n", o_nval, 10);
    chk("hold_nready0", o_nrdy0, 11);
    clr_obs();
    w = W'($urandom);
    word_in = w;
    repeat (11) cycle();
    chk("hold_bits", o_cap[9:0], w);
    chk("hold_n", o_nval, 10);
    word_valid = 1'b0;
    repeat (3) cycle();

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) btn_raw = ~btn_raw;
      word_valid = ($urandom_range(0, 2) != 0);
      len_in = LW'($urandom_range(0, 15));
      word_in = W'($urandom);
      rst = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst = 1'b1;
    word_valid = 1'b0;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
